// File: rtl/instr_fetch.sv
// Instruction-fetch front end: BOOT -> FETCH -> ISSUE sequencer holding the PC.
// Define FETCH_PERF_EN to add the perf_retired / perf_stall counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  output logic [31:0] pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall,
`endif
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        accept;
  logic        retire;

  assign accept     = (state_q == FETCH) && imem_ack;
  assign retire     = (state_q == ISSUE) && instr_ready;
  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Jump beats branch when the decoder asserts both.
  always_comb begin
    if (is_jump)
      next_pc = {pc_plus4[31:28], addr26, 2'b00};
    else if (is_branch && branch_taken)
      next_pc = pc_plus4 + branch_off;
    else
      next_pc = pc_plus4;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // NOTE: every comb output is defaulted first so no path leaves it unassigned
  // and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: if (accept) begin
        instr_d = imem_rdata;
        state_d = ISSUE;
      end
      ISSUE: if (retire) begin
        pc_d    = next_pc;
        state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == FETCH);
    instr_valid = (state_q == ISSUE);
    imem_addr   = pc_q;
    pc          = pc_q;
    instruction = instr_q;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'h0;
      stall_q   <= 32'h0;
    end else begin
      if (retire)
        retired_q <= retired_q + 32'd1;
      if ((state_q == FETCH) && !imem_ack)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: transaction-level model checked every cycle,
// plus hand-computed literal checks; a second instance covers a high RESET_PC.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_HI = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready, ready_hi;
  logic        is_jump, is_branch, branch_taken;
  logic [15:0] imm16;
  logic [25:0] addr26;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, pc, pc_plus4;
  logic        req_hi, valid_hi;
  logic [31:0] addr_hi, instr_hi, pc_hi, pc4_hi;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_retired, perf_stall, retired_hi, stall_hi;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken),
    .imm16(imm16), .addr26(addr26), .pc(pc),
`ifdef FETCH_PERF_EN
    .perf_retired(perf_retired), .perf_stall(perf_stall),
`endif
    .pc_plus4(pc_plus4)
  );

  instr_fetch #(.RESET_PC(RESET_PC_HI)) u_dut_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req_hi), .imem_addr(addr_hi), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instr_hi), .instr_valid(valid_hi), .instr_ready(ready_hi),
    .is_jump(is_jump), .is_branch(is_branch), .branch_taken(branch_taken),
    .imm16(imm16), .addr26(addr26), .pc(pc_hi),
`ifdef FETCH_PERF_EN
    .perf_retired(retired_hi), .perf_stall(stall_hi),
`endif
    .pc_plus4(pc4_hi)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic j, input logic b,
                                              input logic t, input logic [15:0] imm,
                                              input logic [25:0] tgt);
    longint seq, off;
    seq = longint'(cur) + 4;
    if (j) return 32'((seq & 64'hF000_0000) + (longint'(tgt) * 4));
    off = longint'($signed(imm)) * 4;
    if (b && t) return 32'(seq + off);
    return 32'(seq);
  endfunction

  // Model: a word is either being requested, being offered, or we are booting.
  logic        m_boot = 1'b1, m_req = 1'b0, m_valid = 1'b0;
  logic [31:0] m_pc = RESET_PC, m_instr = 32'h0;
  logic [31:0] m_retired = 32'h0, m_stall = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1'b1; m_req <= 1'b0; m_valid <= 1'b0;
      m_pc <= RESET_PC; m_instr <= 32'h0;
      m_retired <= 32'h0; m_stall <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_req <= 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr <= imem_rdata; m_valid <= 1'b1; m_req <= 1'b0;
      end else begin
        m_stall <= m_stall + 32'd1;
      end
    end else if (m_valid && instr_ready) begin
      m_pc <= ref_next_pc(m_pc, is_jump, is_branch, branch_taken, imm16, addr26);
      m_valid <= 1'b0; m_req <= 1'b1;
      m_retired <= m_retired + 32'd1;
    end
  end

  always @(negedge clk) begin
    check("cyc_req", {31'h0, imem_req}, {31'h0, m_req});
    check("cyc_valid", {31'h0, instr_valid}, {31'h0, m_valid});
    check("cyc_pc", pc, m_pc);
    check("cyc_pc_plus4", pc_plus4, m_pc + 32'd4);
    if (m_req) check("cyc_addr", imem_addr, m_pc);
    if (m_valid || !rst_n) check("cyc_instr", instruction, m_instr);
`ifdef FETCH_PERF_EN
    check("cyc_perf_retired", perf_retired, m_retired);
    check("cyc_perf_stall", perf_stall, m_stall);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] d, input int waits);
    for (int i = 0; i < waits; i++) tick();
    imem_ack = 1'b1; imem_rdata = d;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic retire(input logic j, input logic b, input logic t,
                        input logic [15:0] imm, input logic [25:0] tgt);
    is_jump = j; is_branch = b; branch_taken = t; imm16 = imm; addr26 = tgt;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0; imm16 = 16'h0; addr26 = 26'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef FETCH_PERF_EN
    logic [31:0] stall0;
`endif
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0; ready_hi = 1'b0;
    is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0; imm16 = 16'h0; addr26 = 26'h0;
    tick(); tick();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("hi_rst_pc", pc_hi, 32'h3000_0010);

    // BOOT with the memory already acking: ignored, then fetched in the first FETCH cycle.
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2010_FEFE;
    #1 check("boot_req", {31'h0, imem_req}, 32'h0);
    tick();
    check("boot_no_load", {31'h0, instr_valid}, 32'h0);
    check("fetch_req", {31'h0, imem_req}, 32'h1);
    check("fetch_addr", imem_addr, 32'h0);
    tick();
    imem_ack = 1'b0;
    check("first_instr", instruction, 32'h2010_FEFE);
    check("first_valid", {31'h0, instr_valid}, 32'h1);

    retire(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    check("seq_addr", imem_addr, 32'h4);
    fetch(32'h0000_0001, 0);
    check("pc_plus4_8", pc_plus4, 32'h8);

    retire(1'b1, 1'b0, 1'b0, 16'h0, 26'h40);
    check("jump_pc", pc, 32'h100);
    fetch(32'h0000_0002, 0);
    retire(1'b0, 1'b1, 1'b1, 16'hFFFD, 26'h0);
    check("br_taken", pc, 32'h0F8);
    fetch(32'h0000_0003, 0);
    retire(1'b1, 1'b0, 1'b0, 16'h0, 26'h40);
    fetch(32'h0000_0004, 0);
    retire(1'b0, 1'b1, 1'b0, 16'hFFFD, 26'h0);
    check("br_not_taken", pc, 32'h104);

    // Second instance retires its first word with jump and branch both asserted.
    is_jump = 1'b1; is_branch = 1'b1; branch_taken = 1'b1; imm16 = 16'h0004; addr26 = 26'h40;
    ready_hi = 1'b1;
    tick();
    ready_hi = 1'b0;
    is_jump = 1'b0; is_branch = 1'b0; branch_taken = 1'b0; imm16 = 16'h0; addr26 = 26'h0;
    check("hi_jump_wins", pc_hi, 32'h3000_0100);

    // Slow memory: ack on the third FETCH cycle, address held throughout.
`ifdef FETCH_PERF_EN
    stall0 = perf_stall;
`endif
    check("slow_addr0", imem_addr, 32'h104);
    tick();
    check("slow_addr1", imem_addr, 32'h104);
    tick();
    check("slow_addr2", imem_addr, 32'h104);
    fetch(32'hA5A5_0003, 0);
    check("slow_instr", instruction, 32'hA5A5_0003);
`ifdef FETCH_PERF_EN
    check("slow_perf_stall", perf_stall, stall0 + 32'd2);
`endif
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("stray_ack_instr", instruction, 32'hA5A5_0003);
    check("stray_ack_valid", {31'h0, instr_valid}, 32'h1);

    // Wrap: branch backwards from 0 to the top word, then fall through to 0.
    retire(1'b1, 1'b0, 1'b0, 16'h0, 26'h0);
    check("jump_zero", pc, 32'h0);
    fetch(32'h0000_0005, 1);
    retire(1'b0, 1'b1, 1'b1, 16'hFFFE, 26'h0);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    fetch(32'h0000_0006, 0);
    retire(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    check("wrap_addr", imem_addr, 32'h0);
    fetch(32'h0000_0007, 0);
    retire(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    check("pre_rst_pc", pc, 32'h4);

    // Reset in the middle of a FETCH, then an ack during BOOT.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", {31'h0, imem_req}, 32'h0);
    check("midrst_pc", pc, RESET_PC);
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00; rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("bootack_valid", {31'h0, instr_valid}, 32'h0);
    check("bootack_instr", instruction, 32'h0);
    check("bootack_req", {31'h0, imem_req}, 32'h1);
    fetch(32'h1234_5678, 0);
    check("post_rst_instr", instruction, 32'h1234_5678);
    retire(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
